// File: rtl/gpio_bank_pkg.sv
// Shared constants for the gpio_bank peripheral: register map, address window
// and synchroniser limits.
package gpio_bank_pkg;

    // Byte offsets of the eight registers inside the window.
    localparam logic [4:0] OFF_OUT     = 5'h00;
    localparam logic [4:0] OFF_DIR     = 5'h04;
    localparam logic [4:0] OFF_IN      = 5'h08;
    localparam logic [4:0] OFF_SET     = 5'h0C;
    localparam logic [4:0] OFF_CLR     = 5'h10;
    localparam logic [4:0] OFF_RISE_EN = 5'h14;
    localparam logic [4:0] OFF_FALL_EN = 5'h18;
    localparam logic [4:0] OFF_STATUS  = 5'h1C;

    // Word indices as seen on Adr_in[4:2].
    localparam logic [2:0] IDX_OUT     = OFF_OUT[4:2];
    localparam logic [2:0] IDX_DIR     = OFF_DIR[4:2];
    localparam logic [2:0] IDX_IN      = OFF_IN[4:2];
    localparam logic [2:0] IDX_SET     = OFF_SET[4:2];
    localparam logic [2:0] IDX_CLR     = OFF_CLR[4:2];
    localparam logic [2:0] IDX_RISE_EN = OFF_RISE_EN[4:2];
    localparam logic [2:0] IDX_FALL_EN = OFF_FALL_EN[4:2];
    localparam logic [2:0] IDX_STATUS  = OFF_STATUS[4:2];

    localparam logic [31:0] WINDOW_SIZE = 32'h20;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Priming counter must reach SYNC_STAGES_MAX+1 = 5.
    localparam int PRIME_W = 3;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser chain plus a one-cycle history register that yields raw
// per-pin rise/fall pulses; enabling and priming are applied by the parent.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    import gpio_bank_pkg::*;

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction/output registers with atomic set/clear,
// synchronised inputs and per-pin edge interrupts with write-1-to-clear status.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      Adr_in,
    input  logic             MemWrite_in,
    input  logic [31:0]      Data_in,
    output logic [31:0]      Data_out,
    output logic             hit,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    // Bus protocol: single-cycle access, no handshake. A write is accepted on
    // the edge where MemWrite_in and hit are both high; reads are combinational.

    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   dir_q;
    logic [WIDTH-1:0]   rise_en_q;
    logic [WIDTH-1:0]   fall_en_q;
    logic [WIDTH-1:0]   status_q;
    logic [PRIME_W-1:0] prime_cnt;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise_raw;
    logic [WIDTH-1:0] fall_raw;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_field;
    logic [2:0]       reg_idx;
    logic             wr_en;
    logic             prime_done;

    // Window is 32-byte aligned, so an upper-bit compare covers the full range.
    assign hit     = (Adr_in[31:5] == BASE_ADDR[31:5]);
    assign reg_idx = Adr_in[4:2];
    assign wr_en   = MemWrite_in & hit;
    assign wdata   = Data_in[WIDTH-1:0];

    logic unused_bits;
    assign unused_bits = ^{Adr_in[1:0], Data_in};

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .pins (gpio_in),
        .sync (sync_in),
        .rise (rise_raw),
        .fall (fall_raw)
    );

    // Edges stay masked until the chain and prev hold real pin samples.
    assign prime_done = (prime_cnt == PRIME_W'(SYNC_STAGES + 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (!prime_done) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    assign edge_set   = prime_done ? ((rise_raw & rise_en_q) | (fall_raw & fall_en_q))
                                   : '0;
    assign status_clr = (wr_en && reg_idx == IDX_STATUS) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            if (wr_en) begin
                case (reg_idx)
                    IDX_OUT:     out_q     <= wdata;
                    IDX_DIR:     dir_q     <= wdata;
                    IDX_SET:     out_q     <= out_q | wdata;
                    IDX_CLR:     out_q     <= out_q & ~wdata;
                    IDX_RISE_EN: rise_en_q <= wdata;
                    IDX_FALL_EN: fall_en_q <= wdata;
                    default:     ;
                endcase
            end
            // A new edge overrides a simultaneous clear of the same bit.
            status_q <= (status_q & ~status_clr) | edge_set;
        end
    end

    always_comb begin
        rd_field = '0;
        case (reg_idx)
            IDX_OUT:     rd_field = out_q;
            IDX_DIR:     rd_field = dir_q;
            IDX_IN:      rd_field = sync_in;
            IDX_RISE_EN: rd_field = rise_en_q;
            IDX_FALL_EN: rd_field = fall_en_q;
            IDX_STATUS:  rd_field = status_q;
            default:     rd_field = '0;
        endcase
    end

    always_comb begin
        Data_out = '0;
        if (hit) begin
            Data_out[WIDTH-1:0] = rd_field;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with a register-level reference model compared
// every cycle, plus literal expectations from the register map and latencies.
module tb_gpio_bank;

    localparam int          W    = 8;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [31:0] MASK = 32'h0000_00FF;

    logic          clk;
    logic          rst;
    logic [31:0]   Adr_in;
    logic          MemWrite_in;
    logic [31:0]   Data_in;
    logic [31:0]   Data_out;
    logic          hit;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int checks = 0;
    int errors = 0;

    gpio_bank #(
        .WIDTH       (W),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Adr_in      (Adr_in),
        .MemWrite_in (MemWrite_in),
        .Data_in     (Data_in),
        .Data_out    (Data_out),
        .hit         (hit),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Registers held as plain words; pin history is a queue of per-edge samples,
    // so IN is simply the pin value sampled SYNC_STAGES edges ago.
    logic [31:0]  m_out, m_dir, m_re, m_fe, m_st;
    logic [W-1:0] hist[$];
    int           m_n;

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'h20);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (in_window(a)) begin
            case ((a - BASE) >> 2)
                0: r = m_out;
                1: r = m_dir;
                2: r = 32'(hist[hist.size() - S]);
                5: r = m_re;
                6: r = m_fe;
                7: r = m_st;
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    initial begin : model_and_compare
        logic [31:0] syn, prv, edges, wd, clr;
        @(posedge clk);
        forever begin
            if (rst) begin
                m_out = 0; m_dir = 0; m_re = 0; m_fe = 0; m_st = 0;
                hist.delete();
                for (int i = 0; i <= S; i++) hist.push_back('0);
                m_n = 0;
            end else begin
                syn   = 32'(hist[hist.size() - S]);
                prv   = 32'(hist[hist.size() - S - 1]);
                edges = (m_n >= S + 1) ? ((syn & ~prv & m_re) | (~syn & prv & m_fe)) : 32'h0;
                wd    = Data_in & MASK;
                clr   = 32'h0;
                if (MemWrite_in && in_window(Adr_in)) begin
                    case ((Adr_in - BASE) >> 2)
                        0: m_out = wd;
                        1: m_dir = wd;
                        3: m_out = m_out | wd;
                        4: m_out = m_out & ~wd;
                        5: m_re  = wd;
                        6: m_fe  = wd;
                        7: clr   = wd;
                        default: ;
                    endcase
                end
                m_st = (m_st & ~clr) | edges;
                hist.push_back(gpio_in);
                void'(hist.pop_front());
                if (m_n < 1000) m_n++;
            end
            #2;
            check("model_gpio_out", 32'(gpio_out), m_out);
            check("model_gpio_oe",  32'(gpio_oe),  m_dir);
            check("model_irq",      32'(irq),      32'(m_st != 0));
            check("model_hit",      32'(hit),      32'(in_window(Adr_in)));
            check("model_data_out", Data_out,      model_read(Adr_in));
            @(posedge clk);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        @(negedge clk);
        Adr_in      = BASE + off;
        Data_in     = data;
        MemWrite_in = 1'b1;
        @(negedge clk);
        MemWrite_in = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
        Adr_in      = BASE + off;
        MemWrite_in = 1'b0;
        #1;
        check(name, Data_out, exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; Adr_in = 32'h0; MemWrite_in = 1'b0; Data_in = 32'h0; gpio_in = '0;
        cycles(3);
        rst = 1'b0;
        cycles(1);

        for (int i = 0; i < 8; i++) rd_check("reset_read", 32'(i * 4), 32'h0);
        check("reset_oe",  32'(gpio_oe),  32'h0);
        check("reset_out", 32'(gpio_out), 32'h0);
        check("reset_irq", 32'(irq),      32'h0);
        Adr_in = BASE + 32'h20; #1;
        check("hit_above", 32'(hit), 32'h0);
        check("data_above", Data_out, 32'h0);
        Adr_in = BASE - 32'h1; #1;
        check("hit_below", 32'(hit), 32'h0);
        Adr_in = BASE + 32'h1F; #1;
        check("hit_top", 32'(hit), 32'h1);

        wr(32'h00, 32'hA5); check("out_write", 32'(gpio_out), 32'hA5);
        wr(32'h0C, 32'h0F); check("out_set",   32'(gpio_out), 32'hAF);
        wr(32'h10, 32'h81); check("out_clr",   32'(gpio_out), 32'h2E);
        rd_check("read_out", 32'h00, 32'h2E);
        rd_check("read_set", 32'h0C, 32'h0);
        rd_check("read_clr", 32'h10, 32'h0);

        wr(32'h04, 32'hFFFF_FF3C); check("dir_oe", 32'(gpio_oe), 32'h3C);
        rd_check("read_dir", 32'h04, 32'h0000_003C);
        wr(32'h08, 32'hFF);
        rd_check("in_write_ignored", 32'h08, 32'h0);

        // Rise on pin 0: IN after k+1, STATUS/irq after k+2.
        wr(32'h14, 32'h01);
        gpio_in = 8'h01;
        @(negedge clk);
        rd_check("in_lat_k", 32'h08, 32'h0);
        @(negedge clk);
        rd_check("in_lat_k1", 32'h08, 32'h1);
        check("irq_lat_k1", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_lat_k2", 32'(irq), 32'h1);
        rd_check("status_rise0", 32'h1C, 32'h1);
        wr(32'h1C, 32'h01);
        check("irq_w1c", 32'(irq), 32'h0);
        rd_check("status_w1c", 32'h1C, 32'h0);

        // Pins high through reset: priming must swallow the apparent rise.
        gpio_in = 8'hFF;
        rst = 1'b1;
        cycles(2);
        check("rst2_out", 32'(gpio_out), 32'h0);
        check("rst2_oe",  32'(gpio_oe),  32'h0);
        rst = 1'b0;
        wr(32'h14, 32'hFF);
        cycles(5);
        rd_check("prime_status", 32'h1C, 32'h0);
        check("prime_irq", 32'(irq), 32'h0);
        rd_check("prime_in", 32'h08, 32'hFF);

        wr(32'h18, 32'h08);
        gpio_in = 8'hF7;
        cycles(3);
        rd_check("fall3_status", 32'h1C, 32'h08);
        check("fall3_irq", 32'(irq), 32'h1);
        wr(32'h1C, 32'hFF);
        rd_check("status_clr_all", 32'h1C, 32'h0);

        // Pin 2: fall not enabled, then rise sets bit 2.
        gpio_in = 8'hF3;
        cycles(3);
        rd_check("fall2_ignored", 32'h1C, 32'h0);
        gpio_in = 8'hF7;
        cycles(3);
        rd_check("rise2_status", 32'h1C, 32'h04);
        gpio_in = 8'hF3;
        cycles(3);
        wr(32'h14, 32'h00);
        rd_check("disable_keeps", 32'h1C, 32'h04);
        wr(32'h14, 32'hFF);

        // W1C of bit 2 on the same edge as a new rise on pin 2.
        gpio_in = 8'hF7;
        cycles(2);
        Adr_in = BASE + 32'h1C; Data_in = 32'h04; MemWrite_in = 1'b1;
        @(negedge clk);
        MemWrite_in = 1'b0;
        rd_check("w1c_vs_set", 32'h1C, 32'h04);
        check("w1c_vs_set_irq", 32'(irq), 32'h1);

        // Reset mid-stream.
        wr(32'h00, 32'h55);
        check("pre_rst_out", 32'(gpio_out), 32'h55);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out", 32'(gpio_out), 32'h0);
        check("midrst_oe",  32'(gpio_oe),  32'h0);
        check("midrst_irq", 32'(irq),      32'h0);
        rd_check("midrst_status", 32'h1C, 32'h0);
        rst = 1'b0;
        cycles(6);
        rd_check("post_rst_status", 32'h1C, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised memory-mapped GPIO peripheral, successor to the fixed 8-bit LED/switch GPIO on the RISC-V SoC bus. It provides `WIDTH` bidirectional channels with a direction register, atomic set/clear writes, metastability-synchronised inputs, and per-pin rising/falling-edge interrupts with write-1-to-clear status. It sits behind the peripherals control unit alongside ROM and RAM. It drives a `hit` flag so the control unit can select its read data.

## Interface
- `WIDTH`, 8: number of GPIO channels, 1..32.
- `BASE_ADDR`, 32'h0000_0400: byte address of register 0; must be 32-byte aligned.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Adr_in`  in  32  CPU byte address.
- `MemWrite_in`  in  1  write strobe for the current cycle.
- `Data_in`  in  32  CPU write data.
- `Data_out`  out  32  read data, combinational from address and registers.
- `hit`  out  1  high when `Adr_in` is in [BASE_ADDR, BASE_ADDR+0x1F].
- `gpio_in`  in  WIDTH  asynchronous pin inputs.
- `gpio_out`  out  WIDTH  output register value.
- `gpio_oe`  out  WIDTH  per-pin output enable (1 = drive).
- `irq`  out  1  OR of all pending status bits.

## Operation
- Decode uses `Adr_in[4:2]` when `hit` is set. Bits [1:0] are ignored. Each register below is listed with its byte offset.
  - 0x00 OUT: read/write output register.
  - 0x04 DIR: read/write; 1 = output.
  - 0x08 IN: read-only; synchronised pin value.
  - 0x0C SET: write-only; OUT |= data.
  - 0x10 CLR: write-only; OUT &= ~data.
  - 0x14 RISE_EN: read/write.
  - 0x18 FALL_EN: read/write.
  - 0x1C STATUS: read/write-1-to-clear.
- SET and CLR read as 0.
- Writes to IN have no effect.
- Only bits [WIDTH-1:0] are stored. Upper data bits are ignored on write and read as 0.
- `Data_out` = 0 when `hit` = 0.
- Writes take effect only when `MemWrite_in` = 1 and `hit` = 1.
- Edge detection:
  - `prev` holds the synchroniser output from the previous cycle.
  - rise = sync & ~prev & RISE_EN.
  - fall = ~sync & prev & FALL_EN.
  - STATUS bit sets on rise | fall.
- Priming: after reset, a counter suppresses edge detection for SYNC_STAGES+1 cycles. This prevents a pin that is high at reset from producing a spurious rise.
- Simultaneous STATUS W1C and a new edge on the same bit: set wins, bit stays 1.
- Disabling RISE_EN/FALL_EN does not clear pending STATUS bits.
- `irq` = |STATUS. It is combinational from the register and has no extra delay.

## Timing
- Reset values:
  - OUT, DIR, RISE_EN, FALL_EN, STATUS, synchroniser flops and `prev` = 0.
  - Priming counter = 0.
  - Resulting outputs: `gpio_out` = 0, `gpio_oe` = 0, `irq` = 0.
- Register write at edge N is visible on `gpio_out`/`gpio_oe` and in read data after edge N.
- Input latency for a pin change stable before edge k:
  - IN reads the new value after edge k+SYNC_STAGES-1.
  - STATUS and `irq` assert after edge k+SYNC_STAGES.
- Pulses shorter than one clock period may be missed; no pulse stretching.
- Reset mid-operation: all state returns to reset values on the next edge and priming restarts. Pin values are ignored during reset.
- Reads have zero wait states. `Data_out` is valid in the same cycle as `Adr_in`.

## Structure
- Package `gpio_bank_pkg`:
  - register offset constants (OFF_OUT .. OFF_STATUS);
  - address-window size 32'h20;
  - SYNC_STAGES bounds.
- Sub-module `gpio_sync_edge`:
  - parameters WIDTH and SYNC_STAGES;
  - contains the synchroniser chain, the `prev` register and the rise/fall outputs;
  - instantiated once, gated by the priming counter in the parent.
- Parent contains the address decode, register file, STATUS set/clear logic and read mux.

## Test plan
- Reset, then read all 8 offsets -> all read 0; `gpio_oe` = 0; `irq` = 0; address BASE+0x20 -> `hit` = 0, `Data_out` = 0.
- Write OUT = 0xA5, SET = 0x0F, CLR = 0x81 -> `gpio_out` steps 0xA5, 0xAF, 0x2E. Reading OUT returns 0x2E; reading SET returns 0.
- WIDTH = 8: write DIR = 32'hFFFF_FF3C -> `gpio_oe` = 0x3C; read DIR = 32'h0000_003C.
- RISE_EN = 0x01, `gpio_in[0]` 0->1 before edge k -> IN[0] = 1 after edge k+1; STATUS = 0x01 and `irq` = 1 after edge k+2. Write STATUS = 0x01 -> `irq` = 0.
- `gpio_in` = 0xFF held through reset release with RISE_EN = 0xFF preloaded after priming -> STATUS stays 0. Then toggle pin 3 low with FALL_EN = 0x08 -> STATUS = 0x08.
- W1C of STATUS bit 2 in the same cycle as a new rise on pin 2 -> bit 2 remains 1. Assert `rst` mid-stream -> all outputs 0 on the next edge.
